// File: rtl/axisv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axisv_pkg : shared FSM state type and raster timing helpers          |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package axisv_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    RUN  = 2'd1,
    SYNC = 2'd2
  } lcd_state_e;

  function automatic int unsigned lcd_total(input int unsigned active_cnt,
                                            input int unsigned fp,
                                            input int unsigned sync_w,
                                            input int unsigned bp);
    return active_cnt + fp + sync_w + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axisv_lcd_out_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axisv_lcd_out_if : AXI4-Stream pixel bus (tuser[0] = end of frame)   |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
interface axisv_lcd_out_if #(
  parameter int unsigned DATA_WIDTH = 18
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [0:0]            tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/axisv_lcd_timing.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axisv_lcd_timing : free-running h/v raster counters and decodes      |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module axisv_lcd_timing
  import axisv_pkg::*;
#(
  parameter int unsigned H_PIXEL_COUNT = 480,
  parameter int unsigned V_PIXEL_COUNT = 272,
  parameter int unsigned H_FP          = 2,
  parameter int unsigned H_SYNC        = 41,
  parameter int unsigned H_BP          = 2,
  parameter int unsigned V_FP          = 2,
  parameter int unsigned V_SYNC        = 10,
  parameter int unsigned V_BP          = 2
) (
  input  logic aclk_i,
  input  logic rst_ni,
  output logic active_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic frame_start_o,
  output logic frame_req_o,
  output logic last_col_o,
  output logic last_row_o
);

  localparam int unsigned H_TOTAL = lcd_total(H_PIXEL_COUNT, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = lcd_total(V_PIXEL_COUNT, V_FP, V_SYNC, V_BP);
  localparam int          HW      = $clog2(H_TOTAL);
  localparam int          VW      = $clog2(V_TOTAL);
  localparam int unsigned HS_BEG  = H_PIXEL_COUNT + H_FP;
  localparam int unsigned HS_END  = H_PIXEL_COUNT + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_PIXEL_COUNT + V_FP;
  localparam int unsigned VS_END  = V_PIXEL_COUNT + V_FP + V_SYNC;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_wrap, v_wrap;
  logic          frame_req_q, frame_req_d;

  always_comb begin
    h_wrap = (h_q == HW'(H_TOTAL - 1));
    v_wrap = (v_q == VW'(V_TOTAL - 1));
    h_d    = h_wrap ? '0 : h_q + HW'(1);
    v_d    = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + VW'(1);
    end
    // Decoded one clock early so the registered pulse lands on h==0, v==V_PIXEL_COUNT
    frame_req_d = h_wrap && (v_q == VW'(V_PIXEL_COUNT - 1));
  end

  always_ff @(posedge aclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q         <= '0;
      v_q         <= '0;
      frame_req_q <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      frame_req_q <= frame_req_d;
    end
  end

  assign active_o      = (h_q < HW'(H_PIXEL_COUNT)) && (v_q < VW'(V_PIXEL_COUNT));
  assign hsync_o       = (h_q >= HW'(HS_BEG)) && (h_q < HW'(HS_END));
  assign vsync_o       = (v_q >= VW'(VS_BEG)) && (v_q < VW'(VS_END));
  assign frame_start_o = h_wrap && v_wrap;
  assign frame_req_o   = frame_req_q;
  assign last_col_o    = (h_q == HW'(H_PIXEL_COUNT - 1));
  assign last_row_o    = (v_q == VW'(V_PIXEL_COUNT - 1));

endmodule
`default_nettype wire

// File: rtl/axisv_lcd_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axisv_lcd_out : AXI4-Stream to parallel RGB LCD with frame resync    |
// | Optional err_cnt_o output enabled by macro AXISV_LCD_ERRCNT_EN       |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module axisv_lcd_out
  import axisv_pkg::*;
#(
  parameter int unsigned H_PIXEL_COUNT = 480,
  parameter int unsigned V_PIXEL_COUNT = 272,
  parameter int unsigned H_FP          = 2,
  parameter int unsigned H_SYNC        = 41,
  parameter int unsigned H_BP          = 2,
  parameter int unsigned V_FP          = 2,
  parameter int unsigned V_SYNC        = 10,
  parameter int unsigned V_BP          = 2,
  parameter int unsigned DATA_WIDTH    = 18
) (
  input  logic                  aclk_i,
  input  logic                  rst_ni,
  axisv_lcd_out_if.slave        s_axis,
  output logic [DATA_WIDTH-1:0] lcd_data_o,
  output logic                  lcd_de_o,
  output logic                  lcd_hsync_o,
  output logic                  lcd_vsync_o,
  output logic                  frame_req_o,
  output logic                  underflow_o,
  output logic                  framing_err_o
`ifdef AXISV_LCD_ERRCNT_EN
  ,
  output logic [15:0]           err_cnt_o
`endif
);

  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_SYNC = SYNC;

  logic                  active, hsync, vsync, frame_start, last_col, last_row;
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  de_q, hsync_q, vsync_q;
  logic                  underflow_q, underflow_d;
  logic                  framing_q, framing_d;
  logic                  tready;
  logic                  eof_pos;

  axisv_lcd_timing #(
    .H_PIXEL_COUNT(H_PIXEL_COUNT),
    .V_PIXEL_COUNT(V_PIXEL_COUNT),
    .H_FP         (H_FP),
    .H_SYNC       (H_SYNC),
    .H_BP         (H_BP),
    .V_FP         (V_FP),
    .V_SYNC       (V_SYNC),
    .V_BP         (V_BP)
  ) u_timing (
    .aclk_i       (aclk_i),
    .rst_ni       (rst_ni),
    .active_o     (active),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .frame_start_o(frame_start),
    .frame_req_o  (frame_req_o),
    .last_col_o   (last_col),
    .last_row_o   (last_row)
  );

  assign eof_pos = last_col && last_row;

  always_comb begin
    state_d     = state_q;
    data_d      = '0;
    underflow_d = 1'b0;
    framing_d   = 1'b0;
    tready      = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (frame_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        tready = active;
        if (active) begin
          if (s_axis.tvalid) begin
            data_d = s_axis.tdata;
            // A misplaced marker is still shown; only the missing-beat case blanks the pixel
            if ((s_axis.tlast != last_col) || (s_axis.tuser[0] != eof_pos)) begin
              framing_d = 1'b1;
              state_d   = ST_SYNC;
            end else if (eof_pos) begin
              state_d = ST_WAIT;
            end
          end else begin
            underflow_d = 1'b1;
            state_d     = ST_SYNC;
          end
        end
      end
      ST_SYNC: begin
        tready = 1'b1;
        if (s_axis.tvalid && s_axis.tlast && s_axis.tuser[0]) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge aclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_WAIT;
      data_q      <= '0;
      de_q        <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      underflow_q <= 1'b0;
      framing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      de_q        <= active;
      hsync_q     <= ~hsync;
      vsync_q     <= ~vsync;
      underflow_q <= underflow_d;
      framing_q   <= framing_d;
    end
  end

  assign s_axis.tready = tready;
  assign lcd_data_o    = data_q;
  assign lcd_de_o      = de_q;
  assign lcd_hsync_o   = hsync_q;
  assign lcd_vsync_o   = vsync_q;
  assign underflow_o   = underflow_q;
  assign framing_err_o = framing_q;

`ifdef AXISV_LCD_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge aclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if ((underflow_d || framing_d) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule
`default_nettype wire
